// File: rtl/wb_pkg.sv
// Shared write-back definitions: register constants, exception codes and
// the multdiv FIFO entry layout used by wb_fifo and wb_arbiter.
package wb_pkg;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam logic [4:0]  RSTATUS_DEFAULT = 5'd30;
  localparam logic [31:0] EXC_MULT        = 32'd4;
  localparam logic [31:0] EXC_DIV         = 32'd5;

  // live is cleared when an entry is popped or overwritten by a younger
  // pipeline write to the same register (WAW kill).
  typedef struct packed {
    logic        live;
    logic [4:0]  regNum;
    logic [31:0] data;
  } wb_entry_t;

  // One-hot register mask, used to build the pending-register vector.
  function automatic logic [31:0] regMask(input logic [4:0] r);
    logic [31:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of multdiv results. Each slot carries a live bit
// that a pipeline write to the same destination can clear (kill port); the
// kill also applies to the entry being pushed in the same cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clock,
  input  logic            rstN,
  input  logic            push,
  input  logic [4:0]      pushReg,
  input  logic [31:0]     pushData,
  input  logic            pop,
  input  logic            killEn,
  input  logic [4:0]      killReg,
  output wb_entry_t       headEntry,
  output logic [CW-1:0]   count,
  output logic [31:0]     pending
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic            pushLive;

  // A same-cycle pipeline write to the pushed register makes the new entry dead.
  assign pushLive  = !(killEn && (killReg == pushReg));
  assign headEntry = mem[rdPtr];

  // Storage, pointers and count; kill, pop and push ordered so push wins its slot.
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (killEn) begin
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].regNum == killReg) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rdPtr].live <= 1'b0;
        rdPtr           <= rdPtr + PW'(1);
      end
      if (push) begin
        mem[wrPtr] <= '{live: pushLive, regNum: pushReg, data: pushData};
        wrPtr      <= wrPtr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Popped and never-written slots are not live, so every live slot is queued.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].live) pending = pending | regMask(mem[i].regNum);
    pending[0] = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port. Pipeline
// writes take priority; multdiv results bypass when the queue is empty and
// the port is free, otherwise they wait in wb_fifo in order.
// Optional feature macro: WB_EXC_RSTATUS_EN (multdiv exceptions write a
// code to RSTATUS instead of the result).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int         DEPTH   = 2,
  parameter logic [4:0] RSTATUS = RSTATUS_DEFAULT,
  localparam int        CW      = $clog2(DEPTH) + 1
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  input  logic        md_is_div,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] md_pending
);

  logic [4:0]    mdReg;
  logic [31:0]   mdData;
  logic          mdXfer;
  logic          mdLive;
  logic          wbIssue;
  logic          fifoEmpty;
  logic [CW-1:0] count;
  wb_entry_t     head;
  logic          push;
  logic          pop;
  logic          issue;
  logic [4:0]    issueReg;
  logic [31:0]   issueData;

`ifdef WB_EXC_RSTATUS_EN
  // Exceptions turn the result into a status code aimed at RSTATUS.
  always_comb begin
    mdReg  = md_reg;
    mdData = md_data;
    if (md_exception) begin
      mdReg  = RSTATUS;
      mdData = md_is_div ? EXC_DIV : EXC_MULT;
    end
  end
`else
  logic unusedExc;
  assign unusedExc = md_exception ^ md_is_div;
  assign mdReg     = md_reg;
  assign mdData    = md_data;
`endif

  // Ready comes from the registered count only: a full queue refuses even
  // when it is popping in the same cycle.
  assign md_ready  = (count < CW'(DEPTH));
  assign mdXfer    = md_valid && md_ready;
  assign mdLive    = (mdReg != REG_ZERO);
  assign wbIssue   = wb_valid && (wb_reg != REG_ZERO);
  assign fifoEmpty = (count == '0);

  // Port arbitration: pipeline, live head, silent drop of killed head, bypass.
  always_comb begin
    issue     = 1'b0;
    issueReg  = REG_ZERO;
    issueData = '0;
    pop       = 1'b0;
    if (wbIssue) begin
      issue     = 1'b1;
      issueReg  = wb_reg;
      issueData = wb_data;
    end else if (!fifoEmpty) begin
      pop = 1'b1;
      if (head.live) begin
        issue     = 1'b1;
        issueReg  = head.regNum;
        issueData = head.data;
      end
    end else if (mdXfer && mdLive) begin
      issue     = 1'b1;
      issueReg  = mdReg;
      issueData = mdData;
    end
    // r0 results are consumed and dropped; a bypassed result is not queued.
    push = mdXfer && mdLive && !(fifoEmpty && !wbIssue);
  end

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clock     (clock),
    .rstN      (ctrl_reset_n),
    .push      (push),
    .pushReg   (mdReg),
    .pushData  (mdData),
    .pop       (pop),
    .killEn    (wbIssue),
    .killReg   (wb_reg),
    .headEntry (head),
    .count     (count),
    .pending   (md_pending)
  );

  // Register-file write port; address/data hold when no write is issued.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= issue;
      if (issue) begin
        ctrl_writeReg <= issueReg;
        data_writeReg <= issueData;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2). Inputs change and outputs are
// sampled 1ns after the rising edge.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_exception;
  logic        md_is_div;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] md_pending;

  int nTot = 0;
  int nBad = 0;

  wb_arbiter #(.DEPTH(2), .RSTATUS(5'd30)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .wb_valid         (wb_valid),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .md_exception     (md_exception),
    .md_is_div        (md_is_div),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .md_pending       (md_pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTot++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    md_valid = 1'b0; md_reg = '0; md_data = '0;
    md_exception = 1'b0; md_is_div = 1'b0;
  endtask

  task automatic setWb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
  endtask

  task automatic setMd(input logic [4:0] r, input logic [31:0] d);
    md_valid = 1'b1; md_reg = r; md_data = d;
  endtask

  task automatic chkWr(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we"},   32'(ctrl_writeEnable), 32'd1);
    chk({tag, ".reg"},  32'(ctrl_writeReg),    32'(r));
    chk({tag, ".data"}, data_writeReg,         d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_reset_n = 1'b0;
    idle();
    tick(); tick();
    // reset state
    chk("rst.we",      32'(ctrl_writeEnable), 32'd0);
    chk("rst.reg",     32'(ctrl_writeReg),    32'd0);
    chk("rst.data",    data_writeReg,         32'd0);
    chk("rst.pending", md_pending,            32'd0);
    chk("rst.ready",   32'(md_ready),         32'd1);
    ctrl_reset_n = 1'b1;
    tick();

    // pipeline write
    setWb(5'd5, 32'hDEADBEEF);
    tick(); idle();
    chkWr("wb", 5'd5, 32'hDEADBEEF);
    tick();
    chk("wb.we_drop", 32'(ctrl_writeEnable), 32'd0);

    // bypass
    setMd(5'd7, 32'd42);
    tick(); idle();
    chkWr("byp", 5'd7, 32'd42);
    chk("byp.pending", md_pending, 32'd0);
    // r0 result discarded
    setMd(5'd0, 32'd99);
    tick(); idle();
    chk("r0.we",      32'(ctrl_writeEnable), 32'd0);
    chk("r0.pending", md_pending,            32'd0);
    tick();
    chk("r0.we2",     32'(ctrl_writeEnable), 32'd0);
    chk("r0.ready",   32'(md_ready),         32'd1);

    // conflict and back-pressure
    setWb(5'd1, 32'h11); setMd(5'd8, 32'h80);
    tick();
    chkWr("cf1", 5'd1, 32'h11);
    chk("cf1.pending", md_pending, 32'h100);
    chk("cf1.ready", 32'(md_ready), 32'd1);
    setWb(5'd2, 32'h22); setMd(5'd9, 32'h90);
    tick();
    chkWr("cf2", 5'd2, 32'h22);
    chk("cf2.pending", md_pending, 32'h300);
    chk("cf2.ready", 32'(md_ready), 32'd0);
    setWb(5'd3, 32'h33); setMd(5'd10, 32'hA0);
    tick();
    chkWr("cf3", 5'd3, 32'h33);
    chk("cf3.pending", md_pending, 32'h300);
    chk("cf3.ready", 32'(md_ready), 32'd0);
    wb_valid = 1'b0;  // reg 10 still offered, refused while full
    tick();
    chkWr("cf4", 5'd8, 32'h80);
    chk("cf4.pending", md_pending, 32'h200);
    chk("cf4.ready", 32'(md_ready), 32'd1);
    tick(); idle();   // reg 10 accepted now, behind reg 9
    chkWr("cf5", 5'd9, 32'h90);
    chk("cf5.pending", md_pending, 32'h400);
    tick();
    chkWr("cf6", 5'd10, 32'hA0);
    chk("cf6.pending", md_pending, 32'd0);
    tick();
    chk("cf7.we", 32'(ctrl_writeEnable), 32'd0);

    // kill of a queued entry
    setWb(5'd2, 32'h2); setMd(5'd9, 32'h99);
    tick(); idle();
    chkWr("k1", 5'd2, 32'h2);
    chk("k1.pending", md_pending, 32'h200);
    setWb(5'd9, 32'd1);
    tick(); idle();
    chkWr("k2", 5'd9, 32'd1);
    chk("k2.pending", md_pending, 32'd0);
    tick();
    chk("k3.we", 32'(ctrl_writeEnable), 32'd0);
    tick();
    chk("k4.we", 32'(ctrl_writeEnable), 32'd0);
    chk("k4.ready", 32'(md_ready), 32'd1);
    // kill of the entry pushed in the same cycle
    setWb(5'd11, 32'h111); setMd(5'd11, 32'h222);
    tick(); idle();
    chkWr("ks1", 5'd11, 32'h111);
    chk("ks1.pending", md_pending, 32'd0);
    tick();
    chk("ks2.we", 32'(ctrl_writeEnable), 32'd0);
    tick();
    chk("ks3.we", 32'(ctrl_writeEnable), 32'd0);

    // exception: divide bypassed, multiply queued
    setMd(5'd4, 32'h1234); md_exception = 1'b1; md_is_div = 1'b1;
    tick(); idle();
`ifdef WB_EXC_RSTATUS_EN
    chkWr("exd", 5'd30, 32'd5);
`else
    chkWr("exd", 5'd4, 32'h1234);
`endif
    setWb(5'd1, 32'h1); setMd(5'd6, 32'h5678); md_exception = 1'b1; md_is_div = 1'b0;
    tick(); idle();
    chkWr("exm1", 5'd1, 32'h1);
`ifdef WB_EXC_RSTATUS_EN
    chk("exm1.pending", md_pending, 32'h4000_0000);
    tick();
    chkWr("exm2", 5'd30, 32'd4);
`else
    chk("exm1.pending", md_pending, 32'h40);
    tick();
    chkWr("exm2", 5'd6, 32'h5678);
`endif
    tick();

    // reset mid-queue
    setWb(5'd1, 32'h1); setMd(5'd12, 32'hC0);
    tick();
    setWb(5'd2, 32'h2); setMd(5'd13, 32'hD0);
    tick();
    chk("rq.pending", md_pending, 32'h3000);
    chk("rq.ready", 32'(md_ready), 32'd0);
    #2 ctrl_reset_n = 1'b0;
    setWb(5'd3, 32'h3); setMd(5'd14, 32'hE0);
    #1;
    chk("rq.we",      32'(ctrl_writeEnable), 32'd0);
    chk("rq.reg",     32'(ctrl_writeReg),    32'd0);
    chk("rq.data",    data_writeReg,         32'd0);
    chk("rq.pend0",   md_pending,            32'd0);
    chk("rq.ready1",  32'(md_ready),         32'd1);
    idle();
    #1 ctrl_reset_n = 1'b1;
    tick();
    chk("rq.we1", 32'(ctrl_writeEnable), 32'd0);
    tick();
    chk("rq.we2", 32'(ctrl_writeEnable), 32'd0);
    chk("rq.pend2", md_pending, 32'd0);
    chk("rq.ready2", 32'(md_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", nTot, nBad);
    $finish;
  end

endmodule
